// File: rtl/aes_req_scheduler.sv
// Two-channel request scheduler in front of a shared pipelined AES-128 core.
// Optional AES_SCHED_STATS_EN adds response and rekey counters.

module aes_req_scheduler_chan #(
  parameter int KEY_LEN = 128
) (
  input  logic [KEY_LEN-1:0] key,
  input  logic [KEY_LEN-1:0] loaded_key,
  input  logic               key_loaded,
  input  logic               grant,
  output logic               key_hit,
  output logic               ready
);
  assign key_hit = key_loaded && (key == loaded_key);
  assign ready   = grant && key_hit;
endmodule

module aes_req_scheduler #(
  parameter int DATA_W    = 128,
  parameter int KEY_LEN   = 128,
  parameter int PIPE_LAT  = 11,
  parameter int KEY_SETUP = 2,
  parameter int TAG_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [KEY_LEN-1:0] req0_key,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [KEY_LEN-1:0] req1_key,
  input  logic [DATA_W-1:0]  req1_data,
  output logic               resp_valid,
  output logic               resp_id,
  output logic [DATA_W-1:0]  resp_data,
  output logic               core_key_valid,
  output logic [KEY_LEN-1:0] core_key,
  output logic               core_data_valid,
  output logic [DATA_W-1:0]  core_data,
  input  logic               core_valid_out,
  input  logic [DATA_W-1:0]  core_cipher_text,
  output logic               busy,
  output logic               err_spurious
`ifdef AES_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_blk0,
  output logic [31:0]        stat_blk1,
  output logic [15:0]        stat_rekey
`endif
);
  localparam int TAG_AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W  = $clog2(PIPE_LAT + 2);
  localparam int FL_W   = $clog2(PIPE_LAT + 1);
  localparam int KS_W   = (KEY_SETUP > 1) ? $clog2(KEY_SETUP + 1) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, KEY_LOAD, KEY_WAIT} state_t;

  state_t state;
  logic   last_grant, sel_lock, issue_id, key_loaded;
  logic [KEY_LEN-1:0] loaded_key;
  logic [KS_W-1:0]    ks_cnt;
  logic [CNT_W-1:0]   inflight;
  logic [FL_W-1:0]    flush_cnt;

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [TAG_AW-1:0]    wp, rp;
  logic [TAG_AW:0]      fifo_cnt;

  logic [1:0]              req_valid, req_ready_v, key_hit_v, grant_v;
  logic [1:0][KEY_LEN-1:0] req_key;
  logic [1:0][DATA_W-1:0]  req_data;
  logic sel, sel_live, sel_open, any_req, hs, ret, spur, flush;

  assign req_valid = {req1_valid, req0_valid};
  assign req_key   = {req1_key, req0_key};
  assign req_data  = {req1_data, req0_data};

  // Selection is live only while accepting; elsewhere it stays on the locked channel.
  always_comb begin
    sel_open = (state == IDLE) || (state == ISSUE);
    any_req  = |req_valid;
    sel_live = (&req_valid) ? ~last_grant : req_valid[1];
    sel      = sel_open ? sel_live : sel_lock;
  end

  for (genvar i = 0; i < 2; i++) begin : g_chan
    assign grant_v[i] = sel_open && req_valid[i] && (sel == 1'(i));
    aes_req_scheduler_chan #(.KEY_LEN(KEY_LEN)) u_chan (
      .key        (req_key[i]),
      .loaded_key (loaded_key),
      .key_loaded (key_loaded),
      .grant      (grant_v[i]),
      .key_hit    (key_hit_v[i]),
      .ready      (req_ready_v[i])
    );
  end

  assign req0_ready = req_ready_v[0];
  assign req1_ready = req_ready_v[1];
  assign hs         = |req_ready_v;
  assign flush      = (flush_cnt != '0);
  assign ret        = core_valid_out && !flush && (fifo_cnt != '0);
  assign spur       = core_valid_out && !flush && (fifo_cnt == '0);
  assign busy       = (state != IDLE) || (inflight != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      sel_lock        <= 1'b0;
      issue_id        <= 1'b0;
      key_loaded      <= 1'b0;
      loaded_key      <= '0;
      ks_cnt          <= '0;
      core_key_valid  <= 1'b0;
      core_key        <= '0;
      core_data_valid <= 1'b0;
      core_data       <= '0;
    end else begin
      core_key_valid  <= 1'b0;
      core_data_valid <= hs;
      if (hs) begin
        core_data  <= req_data[sel];
        issue_id   <= sel;
        last_grant <= sel;
      end
      case (state)
        IDLE, ISSUE: begin
          if (!any_req)
            state <= IDLE;
          else if (key_hit_v[sel])
            state <= ISSUE;
          else begin
            state    <= DRAIN;
            sel_lock <= sel;
          end
        end
        // Reload only once nothing is left in the core under the old key.
        DRAIN: begin
          if ((inflight == '0) && !core_data_valid) begin
            state          <= KEY_LOAD;
            core_key_valid <= 1'b1;
            core_key       <= req_key[sel_lock];
          end
        end
        KEY_LOAD: begin
          loaded_key <= core_key;
          key_loaded <= 1'b1;
          ks_cnt     <= '0;
          state      <= KEY_WAIT;
        end
        KEY_WAIT: begin
          if (ks_cnt == KS_W'(KEY_SETUP - 1))
            state <= ISSUE;
          else
            ks_cnt <= ks_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Results straggling out of the core right after reset belong to dropped blocks.
  always_ff @(posedge clk) begin
    if (!reset)
      flush_cnt <= FL_W'(PIPE_LAT);
    else if (flush)
      flush_cnt <= flush_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      inflight <= '0;
    else begin
      case ({core_data_valid, ret})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (core_data_valid)
      tag_mem[wp] <= issue_id;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp       <= '0;
      rp       <= '0;
      fifo_cnt <= '0;
    end else begin
      if (core_data_valid)
        wp <= (wp == TAG_AW'(TAG_DEPTH - 1)) ? '0 : wp + 1'b1;
      if (ret)
        rp <= (rp == TAG_AW'(TAG_DEPTH - 1)) ? '0 : rp + 1'b1;
      case ({core_data_valid, ret})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
      resp_data    <= '0;
      err_spurious <= 1'b0;
    end else begin
      resp_valid <= ret;
      if (ret) begin
        resp_data <= core_cipher_text;
        resp_id   <= tag_mem[rp];
      end
      if (spur)
        err_spurious <= 1'b1;
    end
  end

`ifdef AES_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_blk0  <= '0;
      stat_blk1  <= '0;
      stat_rekey <= '0;
    end else begin
      if (resp_valid && !resp_id) stat_blk0 <= stat_blk0 + 1'b1;
      if (resp_valid && resp_id)  stat_blk1 <= stat_blk1 + 1'b1;
      if (state == KEY_LOAD)      stat_rekey <= stat_rekey + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Bench for aes_req_scheduler: behavioural AES-128 core model, request drivers,
// in-order scoreboard, vector table and multi-cycle corner sequences.
module tb_aes_req_scheduler;
  localparam int PIPE_LAT  = 11;
  localparam int KEY_SETUP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_key, req0_data, req1_key, req1_data;
  logic         resp_valid, resp_id;
  logic [127:0] resp_data;
  logic         core_key_valid, core_data_valid, core_valid_out;
  logic [127:0] core_key, core_data, core_cipher_text;
  logic         busy, err_spurious;
`ifdef AES_SCHED_STATS_EN
  logic [31:0]  stat_blk0, stat_blk1;
  logic [15:0]  stat_rekey;
`endif

  aes_req_scheduler dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key), .req1_data(req1_data),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .core_key_valid(core_key_valid), .core_key(core_key),
    .core_data_valid(core_data_valid), .core_data(core_data),
    .core_valid_out(core_valid_out), .core_cipher_text(core_cipher_text),
    .busy(busy), .err_spurious(err_spurious)
`ifdef AES_SCHED_STATS_EN
    , .stat_blk0(stat_blk0), .stat_blk1(stat_blk1), .stat_rekey(stat_rekey)
`endif
  );

  localparam logic [127:0] K_F = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_F = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_F = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B = 128'h3925841d02dc09fbdc118597196a0b32;

  // ---------------- behavioural AES-128 ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v};
    return t[(15-n) -: 8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] ct;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
        for (int c = 0; c < 4; c++)
          for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr + 4*((c+rr)%4)];
        s = t;
        if (r < 10)
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
          end
      end
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[4*c+rr] ^= w[4*r+c][31-8*rr -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  // ---------------- bench state ----------------
  typedef struct { logic [127:0] key; logic [127:0] data; } req_t;
  typedef struct { logic id; logic [127:0] ct; } exp_t;
  typedef struct { int due; logic [127:0] ct; } cp_t;
  typedef struct { logic ch; logic [127:0] key; logic [127:0] data; logic [127:0] ct; } vec_t;

  req_t rq0[$], rq1[$];
  exp_t expq[$];
  cp_t  cpq[$];
  int   log_id[$], log_cyc[$];
  logic [127:0] resp_log[$];
  logic [127:0] core_k;
  int   cyc, n_vec, n_err, n_keyload, key_cyc, outstanding, peak, n_resp, gap0, gap1;
  bit   hs0, hs1, inject, rand_gaps;
  logic last_id;
  logic [127:0] last_ct;

  task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic push_req(input bit ch, input logic [127:0] k, input logic [127:0] d);
    req_t r;
    r.key = k; r.data = d;
    if (ch) rq1.push_back(r); else rq0.push_back(r);
  endtask

  // One clock: scoreboard, core model, request drivers, handshake capture.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (resp_valid) begin
      if (expq.size() == 0)
        chk(1'b0, "unexpected_resp", resp_data, 128'h0);
      else begin
        exp_t e = expq.pop_front();
        chk(resp_id == e.id, "resp_id", 128'(resp_id), 128'(e.id));
        chk(resp_data == e.ct, "resp_data", resp_data, e.ct);
      end
      last_id = resp_id; last_ct = resp_data; n_resp++;
      resp_log.push_back(resp_data);
    end
    core_valid_out = 1'b0;
    if (cpq.size() > 0 && cpq[0].due == cyc) begin
      cp_t c = cpq.pop_front();
      core_valid_out = 1'b1; core_cipher_text = c.ct; outstanding--;
    end
    if (inject) begin
      core_valid_out = 1'b1; core_cipher_text = rnd128(); inject = 1'b0;
    end
    if (core_key_valid) begin
      chk(outstanding == 0, "key_while_inflight", 128'(outstanding), 128'h0);
      core_k = core_key; key_cyc = cyc; n_keyload++;
    end
    if (core_data_valid) begin
      cp_t c;
      chk(cyc - key_cyc >= KEY_SETUP + 1, "key_setup_gap", 128'(cyc - key_cyc), 128'(KEY_SETUP + 1));
      c.due = cyc + PIPE_LAT; c.ct = aes128(core_k, core_data);
      cpq.push_back(c); outstanding++;
      if (outstanding > peak) peak = outstanding;
    end
    if (hs0) begin void'(rq0.pop_front()); req0_valid = 1'b0; gap0 = rand_gaps ? int'($urandom_range(0, 3)) : 0; end
    if (hs1) begin void'(rq1.pop_front()); req1_valid = 1'b0; gap1 = rand_gaps ? int'($urandom_range(0, 3)) : 0; end
    if (!req0_valid) begin
      if (gap0 > 0) gap0--;
      else if (rq0.size() > 0) begin req0_valid = 1'b1; req0_key = rq0[0].key; req0_data = rq0[0].data; end
    end
    if (!req1_valid) begin
      if (gap1 > 0) gap1--;
      else if (rq1.size() > 0) begin req1_valid = 1'b1; req1_key = rq1[0].key; req1_data = rq1[0].data; end
    end
    #1;
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    if (req0_ready && req1_ready) chk(1'b0, "dual_ready", 128'h3, 128'h0);
    if (hs0) begin
      exp_t e; e.id = 1'b0; e.ct = aes128(req0_key, req0_data);
      expq.push_back(e); log_id.push_back(0); log_cyc.push_back(cyc);
    end
    if (hs1) begin
      exp_t e; e.id = 1'b1; e.ct = aes128(req1_key, req1_data);
      expq.push_back(e); log_id.push_back(1); log_cyc.push_back(cyc);
    end
  endtask

  task automatic clear_reqs();
    rq0.delete(); rq1.delete(); expq.delete();
    req0_valid = 1'b0; req1_valid = 1'b0; hs0 = 1'b0; hs1 = 1'b0; gap0 = 0; gap1 = 0;
  endtask

  task automatic chk_zero(input string nm);
    chk({resp_valid, resp_id, core_key_valid, core_data_valid, busy, err_spurious, req0_ready, req1_ready} == 8'h00,
        {nm, "_ctrl"}, 128'({resp_valid, resp_id, core_key_valid, core_data_valid, busy, err_spurious, req0_ready, req1_ready}), 128'h0);
    chk(resp_data == 128'h0 && core_data == 128'h0 && core_key == 128'h0, {nm, "_data"}, resp_data | core_data | core_key, 128'h0);
`ifdef AES_SCHED_STATS_EN
    chk({stat_blk0, stat_blk1, stat_rekey} == 80'h0, {nm, "_stats"}, 128'({stat_blk0, stat_blk1, stat_rekey}), 128'h0);
`endif
  endtask

  task automatic do_reset();
    clear_reqs();
    reset = 1'b0;
    step(); step();
    chk_zero("reset");
    reset = 1'b1;
    repeat (PIPE_LAT + 2) step();
  endtask

  task automatic drain_all(input int budget);
    int k = 0;
    while ((rq0.size() > 0 || rq1.size() > 0 || expq.size() > 0 || cpq.size() > 0 || req0_valid || req1_valid) && k < budget) begin
      step(); k++;
    end
    chk(k < budget, "drain_timeout", 128'(k), 128'(budget));
    step(); step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [4];
    int kl0, r0, k;
    bit ok;
    n_vec = 0; n_err = 0; cyc = 0; n_keyload = 0; key_cyc = 0; outstanding = 0; peak = 0; n_resp = 0;
    inject = 1'b0; rand_gaps = 1'b0; core_k = '0; last_id = 1'b0; last_ct = '0;
    req0_key = '0; req0_data = '0; req1_key = '0; req1_data = '0;
    core_valid_out = 1'b0; core_cipher_text = '0;
    build_sbox();
    tbl[0] = '{1'b0, K_F, P_F, C_F};
    tbl[1] = '{1'b1, K_B, P_B, C_B};
    tbl[2] = '{1'b1, K_F, P_F, C_F};
    tbl[3] = '{1'b0, K_B, P_B, C_B};

    do_reset();

    // Single-block vectors, each needing its own key load.
    for (int i = 0; i < 4; i++) begin
      kl0 = n_keyload;
      push_req(tbl[i].ch, tbl[i].key, tbl[i].data);
      drain_all(200);
      chk(last_id == tbl[i].ch, $sformatf("tbl%0d_id", i), 128'(last_id), 128'(tbl[i].ch));
      chk(last_ct == tbl[i].ct, $sformatf("tbl%0d_ct", i), last_ct, tbl[i].ct);
      chk(n_keyload - kl0 == 1, $sformatf("tbl%0d_keyloads", i), 128'(n_keyload - kl0), 128'h1);
      chk(busy == 1'b0, $sformatf("tbl%0d_idle", i), 128'(busy), 128'h0);
    end

    // Same key on both channels: one load, back-to-back alternation, full pipe.
    do_reset();
    log_id.delete(); log_cyc.delete();
    kl0 = n_keyload; peak = 0;
    for (int i = 0; i < 8; i++) begin
      push_req(1'b0, K_F, rnd128());
      push_req(1'b1, K_F, rnd128());
    end
    drain_all(300);
    chk(n_keyload - kl0 == 1, "samekey_loads", 128'(n_keyload - kl0), 128'h1);
    chk(peak == PIPE_LAT, "samekey_peak_inflight", 128'(peak), 128'(PIPE_LAT));
    chk(log_id.size() == 16, "samekey_issues", 128'(log_id.size()), 128'd16);
    ok = 1'b1;
    for (int i = 0; i < log_id.size(); i++)
      if (log_id[i] != i % 2 || log_cyc[i] != log_cyc[0] + i) ok = 1'b0;
    chk(ok, "samekey_alternate_b2b", 128'(ok), 128'h1);

    // Different keys: 0,1,0,1,0 with a reload each time.
    do_reset();
    log_id.delete(); resp_log.delete();
    kl0 = n_keyload;
    push_req(1'b0, K_F, P_F); push_req(1'b0, K_F, rnd128()); push_req(1'b0, K_F, rnd128());
    push_req(1'b1, K_B, P_B); push_req(1'b1, K_B, rnd128());
    drain_all(400);
    chk(n_keyload - kl0 == 5, "diffkey_loads", 128'(n_keyload - kl0), 128'h5);
    ok = (log_id.size() == 5);
    for (int i = 0; i < log_id.size() && i < 5; i++) if (log_id[i] != i % 2) ok = 1'b0;
    chk(ok, "diffkey_order", 128'(log_id.size()), 128'h5);
    chk(resp_log.size() > 1 && resp_log[0] == C_F, "diffkey_ch0_ct", resp_log.size() > 0 ? resp_log[0] : 128'h0, C_F);
    chk(resp_log.size() > 1 && resp_log[1] == C_B, "diffkey_ch1_ct", resp_log.size() > 1 ? resp_log[1] : 128'h0, C_B);
`ifdef AES_SCHED_STATS_EN
    chk(stat_blk0 == 32'd3, "stat_blk0", 128'(stat_blk0), 128'd3);
    chk(stat_blk1 == 32'd2, "stat_blk1", 128'(stat_blk1), 128'd2);
    chk(stat_rekey == 16'd5, "stat_rekey", 128'(stat_rekey), 128'd5);
`endif

    // Reset with five blocks in flight; stragglers fall in the flush window.
    for (int i = 0; i < 8; i++) push_req(1'b0, K_F, rnd128());
    k = 0;
    while (outstanding < 5 && k < 100) begin step(); k++; end
    chk(outstanding == 5, "midreset_inflight", 128'(outstanding), 128'h5);
    clear_reqs();
    reset = 1'b0;
    step();
    chk_zero("midreset");
    step();
    reset = 1'b1;
    r0 = n_resp;
    repeat (PIPE_LAT + 2) step();
    chk(n_resp == r0, "flush_no_resp", 128'(n_resp - r0), 128'h0);
    chk(err_spurious == 1'b0, "flush_no_err", 128'(err_spurious), 128'h0);
    kl0 = n_keyload;
    push_req(1'b0, K_F, P_F);
    drain_all(200);
    chk(n_keyload - kl0 == 1, "reset_clears_key", 128'(n_keyload - kl0), 128'h1);
    chk(last_ct == C_F, "post_reset_ct", last_ct, C_F);

    // Randomized traffic against the scoreboard.
    rand_gaps = 1'b1;
    r0 = n_resp;
    for (int i = 0; i < 30; i++) begin
      push_req(1'b0, ($urandom_range(0, 2) == 0) ? K_B : K_F, rnd128());
      push_req(1'b1, ($urandom_range(0, 2) == 0) ? K_F : K_B, rnd128());
    end
    drain_all(6000);
    rand_gaps = 1'b0;
    chk(n_resp - r0 == 60, "random_resp_count", 128'(n_resp - r0), 128'd60);
    chk(err_spurious == 1'b0, "random_no_err", 128'(err_spurious), 128'h0);
    chk(busy == 1'b0, "random_idle", 128'(busy), 128'h0);

    // Spurious result with empty tag FIFO.
    repeat (3) step();
    r0 = n_resp;
    inject = 1'b1;
    step(); step();
    chk(err_spurious == 1'b1, "spurious_set", 128'(err_spurious), 128'h1);
    repeat (6) step();
    chk(err_spurious == 1'b1, "spurious_sticky", 128'(err_spurious), 128'h1);
    chk(n_resp == r0, "spurious_no_resp", 128'(n_resp - r0), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/aes_req_scheduler.md
Name: aes_req_scheduler

Overview:
- Shares one pipelined AES-128 encryption core between two requesters (channel 0 and channel 1). Each requester supplies its own cipher key.
- Sequences the core: round-robin issue of plaintext blocks, key reloads done only after the pipeline drains, and per-block tag tracking so each ciphertext returns with the id of the channel that issued it.
- Sits between the requesters and the core's data_valid_in / cipherkey_valid_in / valid_out interface.

Parameters:
DATA_W, 128, plaintext/ciphertext width
KEY_LEN, 128, cipher key width
PIPE_LAT, 11, core cycles from core_data_valid to core_valid_out
KEY_SETUP, 2, idle cycles after a core_key_valid pulse before the first data issue
TAG_DEPTH, 16, tag FIFO entries; must be >= PIPE_LAT+1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
req0_valid  in  1  channel 0 block request
req0_ready  out  1  channel 0 accept, combinational from registered state
req0_key  in  KEY_LEN  channel 0 key, held stable while req0_valid
req0_data  in  DATA_W  channel 0 plaintext, held stable while req0_valid
req1_valid / req1_ready / req1_key / req1_data  same as channel 0, for channel 1
resp_valid  out  1  one-cycle pulse: ciphertext available
resp_id  out  1  channel that owns resp_data
resp_data  out  DATA_W  ciphertext
core_key_valid  out  1  key load pulse to core
core_key  out  KEY_LEN  key to core
core_data_valid  out  1  plaintext issue pulse to core
core_data  out  DATA_W  plaintext to core
core_valid_out  in  1  core result valid
core_cipher_text  in  DATA_W  core result
busy  out  1  state != IDLE or inflight != 0
err_spurious  out  1  sticky: core_valid_out seen while tag FIFO empty

Behaviour:
- Reset (reset=0 at a clk edge):
  - All outputs 0.
  - State = IDLE, inflight = 0, tag FIFO emptied, key_loaded = 0, last_grant = 1 (channel 0 wins first).
  - For PIPE_LAT cycles after reset deasserts, core_valid_out is ignored (flush window) and does not set err_spurious.
- States: IDLE, ISSUE, DRAIN, KEY_LOAD, KEY_WAIT.
- Selection:
  - In IDLE/ISSUE, sel = the requesting channel. If both request, sel = !last_grant.
  - Selection is locked from leaving ISSUE until the next return to ISSUE.
- IDLE / ISSUE:
  - If sel key == loaded_key and key_loaded=1: assert reqN_ready for sel only. On valid&&ready, latch data. Next cycle: core_data_valid=1, core_data=latched data, push sel id into tag FIFO, last_grant=sel. Throughput is one block per cycle; alternation occurs when both channels request.
  - Otherwise (mismatch or key_loaded=0): no ready; go to DRAIN.
  - No request: stay in or go to IDLE.
- DRAIN: hold until inflight==0 and no core_data_valid pending, then go to KEY_LOAD.
- KEY_LOAD: core_key_valid=1 and core_key=sel key for exactly one cycle. Set loaded_key=sel key, key_loaded=1. Go to KEY_WAIT.
- KEY_WAIT: count KEY_SETUP cycles, then go to ISSUE with the locked sel.
- inflight:
  - Increments on core_data_valid and decrements on core_valid_out. Both in the same cycle leaves it unchanged.
  - Never exceeds PIPE_LAT.
- Response:
  - On core_valid_out with tag FIFO non-empty: next cycle resp_valid=1, resp_data=core_cipher_text, resp_id=popped tag.
  - There is no backpressure. Latency from req handshake to resp_valid = PIPE_LAT+2.
- core_valid_out with FIFO empty, outside the flush window: set err_spurious; no resp_valid. err_spurious clears only on reset.
- Ordering: responses are strictly in issue order, including across key reloads.
- A requester that drops valid before ready is a protocol violation; the behaviour is undefined.

Optional Feature:
- Macro: AES_SCHED_STATS_EN.
- When defined, adds outputs:
  - stat_blk0 (32 bits): channel 0 responses delivered.
  - stat_blk1 (32 bits): channel 1 responses delivered.
  - stat_rekey (16 bits): KEY_LOAD entries.
  - All three wrap at max, reset to 0, and count only on resp_valid / KEY_LOAD.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- FIPS-197 single block, channel 0 (key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff):
  - one core_key_valid pulse, then after KEY_SETUP one core_data_valid.
  - resp_valid with resp_id=0 and resp_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Same key on both channels, both valid continuously for 8 blocks each:
  - single key load, then issues alternate 0,1,0,1 back-to-back.
  - 16 responses in order with matching ids; inflight peaks at PIPE_LAT.
- Different keys (ch0 = FIPS key, ch1 = 2b7e151628aed2a6abf7158809cf4f3c with data 3243f6a8885a308d313198a2e0370734):
  - DRAIN until inflight=0 before each reload.
  - ch1 result = 3925841d02dc09fbdc118597196a0b32; core_key_valid never asserts while inflight>0.
- Reset asserted mid-stream with 5 blocks in flight:
  - all outputs 0 and key_loaded=0.
  - late core_valid_out within the flush window produces no resp_valid and no err_spurious.
- Spurious core_valid_out injected after the flush window with FIFO empty: err_spurious=1 and stays set; no resp_valid.
- AES_SCHED_STATS_EN defined, run the different-keys scenario (3 ch0 blocks, 2 ch1 blocks, keys alternating 0,1,0,1,0): stat_blk0=3, stat_blk1=2, stat_rekey=5.
